keccak_round_ctrl: RTL and testbench
====================================

# keccak_round_ctrl

Round sequencer for the single-round Keccak-f permutation datapath in the SHA3 core. On a start pulse it steps the round counter from 0 to MaxRound-1 and drives the datapath phase select. It gates the state-register write enable and handshakes per-round entropy for the masked (DOM) chi stage. It also reports busy/done to the SHA3 control FSM and supports an abort that returns it to idle within one cycle.

## Interface
- Width, 1600: Keccak state width; one of {25, 50, 100, 200, 400, 800, 1600}.
- EnMasking, 0: 1 selects the 3-cycle masked round schedule; 0 selects the 1-cycle round schedule.
- Derived (localparam): W = Width/25, L = $clog2(W), MaxRound = 12+2*L, RndW = $clog2(MaxRound+1).

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a permutation; sampled only in IDLE.
- abort_i  in  1  terminate the permutation; return to IDLE next cycle with no done.
- rand_valid_i  in  1  entropy available for the current round.
- rand_ready_o  out  1  entropy consumed this cycle (handshake with rand_valid_i).
- rnd_o  out  RndW  current round index, driven to the datapath rnd input.
- sel_o  out  1  datapath phase select: 0 = theta/rho/pi, 1 = chi/iota.
- dom_valid_o  out  1  drives the datapath rand_valid input.
- state_we_o  out  1  load the datapath output into the state register this cycle.
- busy_o  out  1  permutation in progress.
- done_o  out  1  one-cycle pulse after the final state write.

## Operation
- States: IDLE, P1, P2A, P2B (masked); IDLE, RUN (unmasked). Encode in a single FSM register; unused states decode to IDLE.
- IDLE: all outputs 0, rnd counter held at 0. On start_i=1 and abort_i=0: go to P1 (masked) or RUN (unmasked).
- P1 (masked): sel_o=0, state_we_o=1. Next state is P2A.
- P2A: sel_o=1, dom_valid_o=rand_valid_i, rand_ready_o=rand_valid_i, state_we_o=0.
  - rand_valid_i=1: go to P2B.
  - Otherwise stay in P2A (stall) with sel_o held at 1.
- P2B: sel_o=1, dom_valid_o=0, state_we_o=1.
  - rnd_o==MaxRound-1: go to IDLE, assert done_o next cycle, clear rnd.
  - Otherwise increment rnd and go to P1.
- RUN (unmasked): sel_o=0, state_we_o=1, rand_ready_o=0, dom_valid_o=0 every cycle.
  - rnd_o==MaxRound-1: go to IDLE with done pulse and clear rnd.
  - Otherwise increment rnd.
- busy_o=1 in every state except IDLE.
- Round counter: RndW bits. It never exceeds MaxRound-1; an increment from MaxRound-1 does not occur.
- abort_i in any non-IDLE state:
  - Next state IDLE, rnd cleared, no done_o.
  - state_we_o and rand_ready_o are forced to 0 in the abort cycle.
- start_i while busy: ignored. start_i together with abort_i in IDLE: abort wins, remain IDLE.
- Reset (any state): next cycle IDLE, rnd 0, done_o 0.

## Timing
- Reset values: rnd_o=0, sel_o=0, state_we_o=0, busy_o=0, done_o=0, rand_ready_o=0, dom_valid_o=0.
- Output decode:
  - sel_o, state_we_o, rnd_o, busy_o are Moore outputs decoded from registered state.
  - rand_ready_o and dom_valid_o are combinational from state and rand_valid_i.
  - done_o is registered.
- First active cycle is the cycle after start_i is sampled.
- Latency, start_i to done_o:
  - Masked without stalls: 3*MaxRound+1 cycles (73 at Width=1600).
  - Unmasked: MaxRound+1 cycles (25 at Width=1600).
  - Each P2A stall cycle adds 1.
- Datapath constraint: sel_o stays 1 for at least 2 consecutive cycles after every rise.
- state_we_o is never 1 in a cycle where sel_o rose that same cycle.
- At most one rand_ready_o handshake per round.
- done_o and busy_o are never 1 in the same cycle. A new start_i is accepted in the done_o cycle.

## Test plan
- Unmasked, Width=1600, start pulse:
  - rnd_o steps 0..23 on consecutive cycles with state_we_o=1 throughout.
  - done_o fires 25 cycles after start; busy_o falls in the same cycle.
- Masked, rand_valid_i tied 1:
  - sel_o pattern 0,1,1 repeats 24 times.
  - state_we_o pattern 1,0,1; rand_ready_o 24 pulses; done_o at cycle 73.
- Masked, rand_valid_i low for 5 cycles in round 7 P2A:
  - sel_o held 1, state_we_o 0, rnd_o=7 through the stall.
  - done_o at cycle 78.
- abort_i asserted in round 10 P2B (masked):
  - state_we_o=0 in that cycle; next cycle busy_o=0, rnd_o=0; no done_o.
  - A new start_i then completes normally.
- rst_i asserted mid-run (unmasked, rnd_o=12): next cycle all outputs at reset values.
- start_i during busy and start_i+abort_i in IDLE: both ignored.
- Width=25 (MaxRound=12): done_o at 37 masked and 13 unmasked.

Source files
------------

// File: rtl/keccak_round_ctrl_if.sv
// Control/handshake bundle between the SHA3 control FSM, the entropy source
// and the Keccak round sequencer.
interface keccak_round_ctrl_if #(
  parameter int RndW = 5
);
  logic            start_i;
  logic            abort_i;
  logic            rand_valid_i;
  logic            rand_ready_o;
  logic [RndW-1:0] rnd_o;
  logic            sel_o;
  logic            dom_valid_o;
  logic            state_we_o;
  logic            busy_o;
  logic            done_o;

  modport slave (
    input  start_i, abort_i, rand_valid_i,
    output rand_ready_o, rnd_o, sel_o, dom_valid_o, state_we_o, busy_o, done_o
  );

  modport master (
    output start_i, abort_i, rand_valid_i,
    input  rand_ready_o, rnd_o, sel_o, dom_valid_o, state_we_o, busy_o, done_o
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the single-round Keccak-f datapath: steps the round
// counter, drives the phase select / state write enable and the DOM entropy handshake.
module keccak_round_ctrl #(
  parameter int Width     = 1600,
  parameter bit EnMasking = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  keccak_round_ctrl_if.slave  ctrl_if
);

  localparam int W        = Width / 25;
  localparam int L        = $clog2(W);
  localparam int MaxRound = 12 + 2 * L;
  localparam int RndW     = $clog2(MaxRound + 1);

  localparam logic [RndW-1:0] LastRnd = RndW'(MaxRound - 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StP1   = 3'd1,
    StP2A  = 3'd2,
    StP2B  = 3'd3,
    StRun  = 3'd4
  } state_e;

  state_e          state_q, state_d, cur_state;
  logic [RndW-1:0] rnd_q, rnd_d;
  logic            done_q, done_d;
  logic            last_rnd;
  logic            sel, state_we, busy, rand_ready, dom_valid;

  assign last_rnd = (rnd_q == LastRnd);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // States belonging to the other schedule are treated as IDLE.
    cur_state = state_q;
    if (EnMasking && (state_q == StRun)) begin
      cur_state = StIdle;
    end
    if (!EnMasking && ((state_q == StP1) || (state_q == StP2A) || (state_q == StP2B))) begin
      cur_state = StIdle;
    end
  end

  always_comb begin
    state_d    = StIdle;
    rnd_d      = rnd_q;
    done_d     = 1'b0;
    sel        = 1'b0;
    state_we   = 1'b0;
    busy       = 1'b0;
    rand_ready = 1'b0;
    dom_valid  = 1'b0;

    case (cur_state)
      StIdle: begin
        rnd_d = '0;
        if (ctrl_if.start_i && !ctrl_if.abort_i) begin
          state_d = EnMasking ? StP1 : StRun;
        end
      end
      StP1: begin
        busy     = 1'b1;
        state_we = 1'b1;
        state_d  = StP2A;
      end
      StP2A: begin
        // Chi waits here for fresh entropy; one handshake per round.
        busy       = 1'b1;
        sel        = 1'b1;
        dom_valid  = ctrl_if.rand_valid_i;
        rand_ready = ctrl_if.rand_valid_i;
        state_d    = ctrl_if.rand_valid_i ? StP2B : StP2A;
      end
      StP2B: begin
        busy     = 1'b1;
        sel      = 1'b1;
        state_we = 1'b1;
        if (last_rnd) begin
          state_d = StIdle;
          rnd_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = StP1;
          rnd_d   = rnd_q + RndW'(1);
        end
      end
      StRun: begin
        busy     = 1'b1;
        state_we = 1'b1;
        if (last_rnd) begin
          state_d = StIdle;
          rnd_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = StRun;
          rnd_d   = rnd_q + RndW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        rnd_d   = '0;
      end
    endcase

    // Abort suppresses the pending state write and entropy consumption.
    if (ctrl_if.abort_i && (cur_state != StIdle)) begin
      state_d    = StIdle;
      rnd_d      = '0;
      done_d     = 1'b0;
      state_we   = 1'b0;
      rand_ready = 1'b0;
    end
  end

  assign ctrl_if.rnd_o        = rnd_q;
  assign ctrl_if.done_o       = done_q;
  assign ctrl_if.sel_o        = sel;
  assign ctrl_if.state_we_o   = state_we;
  assign ctrl_if.busy_o       = busy;
  assign ctrl_if.rand_ready_o = rand_ready;
  assign ctrl_if.dom_valid_o  = dom_valid;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: four instances (1600/25 bits,
// masked/unmasked) share stimulus; each scenario checks one instance cycle by cycle.
module tb_keccak_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic rv = 1'b0;

  always #5 clk = ~clk;

  keccak_round_ctrl_if #(.RndW(5)) if_m16 ();
  keccak_round_ctrl_if #(.RndW(5)) if_u16 ();
  keccak_round_ctrl_if #(.RndW(4)) if_m25 ();
  keccak_round_ctrl_if #(.RndW(4)) if_u25 ();

  assign if_m16.start_i = start;  assign if_m16.abort_i = abort;  assign if_m16.rand_valid_i = rv;
  assign if_u16.start_i = start;  assign if_u16.abort_i = abort;  assign if_u16.rand_valid_i = rv;
  assign if_m25.start_i = start;  assign if_m25.abort_i = abort;  assign if_m25.rand_valid_i = rv;
  assign if_u25.start_i = start;  assign if_u25.abort_i = abort;  assign if_u25.rand_valid_i = rv;

  keccak_round_ctrl #(.Width(1600), .EnMasking(1'b1)) u_m16 (.clk_i(clk), .rst_i(rst), .ctrl_if(if_m16));
  keccak_round_ctrl #(.Width(1600), .EnMasking(1'b0)) u_u16 (.clk_i(clk), .rst_i(rst), .ctrl_if(if_u16));
  keccak_round_ctrl #(.Width(25),   .EnMasking(1'b1)) u_m25 (.clk_i(clk), .rst_i(rst), .ctrl_if(if_m25));
  keccak_round_ctrl #(.Width(25),   .EnMasking(1'b0)) u_u25 (.clk_i(clk), .rst_i(rst), .ctrl_if(if_u25));

  typedef struct packed {
    logic [4:0] rnd;
    logic       sel;
    logic       we;
    logic       busy;
    logic       done;
    logic       rr;
    logic       dv;
  } out_t;

  typedef struct packed {
    logic start;
    logic abort;
    logic rv;
    logic rst;
  } stim_t;

  localparam stim_t S_RV = 4'b0010;
  localparam stim_t S_GO = 4'b1010;
  localparam int M16 = 0, U16 = 1, M25 = 2, U25 = 3;

  out_t  exp_q[$];
  stim_t stim_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc;
  int    cut_at;
  bit    cut_rst;
  bit    cut_done;

  function automatic out_t mk(int r, bit sel, bit we, bit busy, bit done, bit rr, bit dv);
    out_t e;
    e.rnd = 5'(r); e.sel = sel; e.we = we; e.busy = busy;
    e.done = done; e.rr = rr; e.dv = dv;
    return e;
  endfunction

  function automatic out_t obs(int which);
    out_t o;
    case (which)
      M16:     o = {5'(if_m16.rnd_o), if_m16.sel_o, if_m16.state_we_o, if_m16.busy_o,
                    if_m16.done_o, if_m16.rand_ready_o, if_m16.dom_valid_o};
      U16:     o = {5'(if_u16.rnd_o), if_u16.sel_o, if_u16.state_we_o, if_u16.busy_o,
                    if_u16.done_o, if_u16.rand_ready_o, if_u16.dom_valid_o};
      M25:     o = {5'(if_m25.rnd_o), if_m25.sel_o, if_m25.state_we_o, if_m25.busy_o,
                    if_m25.done_o, if_m25.rand_ready_o, if_m25.dom_valid_o};
      default: o = {5'(if_u25.rnd_o), if_u25.sel_o, if_u25.state_we_o, if_u25.busy_o,
                    if_u25.done_o, if_u25.rand_ready_o, if_u25.dom_valid_o};
    endcase
    return o;
  endfunction

  // Push one cycle of stimulus plus expected outputs; an abort/reset cut ends the trace.
  function automatic void put(out_t e, stim_t s);
    out_t z;
    z = '0;
    if (cut_done) return;
    if (cyc == cut_at) begin
      if (cut_rst) begin
        s.rst = 1'b1;
      end else begin
        s.abort = 1'b1;
        e.we = 1'b0;
        e.rr = 1'b0;
      end
      exp_q.push_back(e);
      stim_q.push_back(s);
      exp_q.push_back(z);
      stim_q.push_back(4'b0000);
      cut_done = 1'b1;
    end else begin
      exp_q.push_back(e);
      stim_q.push_back(s);
    end
    cyc++;
  endfunction

  // Expected schedule of one permutation, cycle 0 being the start cycle.
  function automatic void build(bit masked, int maxr, int st_rnd, int st_n, int cut, bit crst,
                                bit with_start);
    out_t z;
    z = '0;
    cyc = with_start ? 0 : 1;
    cut_at = cut;
    cut_rst = crst;
    cut_done = 1'b0;
    if (with_start) put(z, S_GO);
    for (int r = 0; r < maxr; r++) begin
      if (masked) begin
        put(mk(r, 0, 1, 1, 0, 0, 0), S_RV);
        if (r == st_rnd) begin
          for (int k = 0; k < st_n; k++) put(mk(r, 1, 0, 1, 0, 0, 0), 4'b0000);
        end
        put(mk(r, 1, 0, 1, 0, 1, 1), S_RV);
        put(mk(r, 1, 1, 1, 0, 0, 0), S_RV);
      end else begin
        put(mk(r, 0, 1, 1, 0, 0, 0), S_RV);
      end
    end
    put(mk(0, 0, 0, 0, 1, 0, 0), S_RV);
  endfunction

  task automatic step(input int which, output out_t o, output out_t e);
    stim_t s;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    @(negedge clk);
    start = s.start;
    abort = s.abort;
    rv    = s.rv;
    rst   = s.rst;
    #1;
    o = obs(which);
  endtask

  task automatic settle;
    @(negedge clk);
    start = 1'b0; abort = 1'b1; rv = 1'b0; rst = 1'b0;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset;
    out_t z;
    z = '0;
    rst = 1'b1; start = 1'b1; abort = 1'b0; rv = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0; rv = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (obs(d) !== z) $display("FAIL reset dut=%0d got=%h exp=%h", d, obs(d), z);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unmasked;
    out_t o, e;
    int c = 0;
    build(1'b0, 24, -1, 0, -1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(U16, o, e);
      n_total++;
      if (o !== e) $display("FAIL unmasked cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  task automatic test_masked_ideal;
    out_t o, e;
    int c = 0;
    build(1'b1, 24, -1, 0, -1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(M16, o, e);
      n_total++;
      if (o !== e) $display("FAIL masked_ideal cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  task automatic test_masked_stall;
    out_t o, e;
    int c = 0;
    build(1'b1, 24, 7, 5, -1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(M16, o, e);
      n_total++;
      if (o !== e) $display("FAIL masked_stall cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  task automatic test_abort;
    out_t o, e;
    int c = 0;
    build(1'b1, 24, -1, 0, 33, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(M16, o, e);
      n_total++;
      if (o !== e) $display("FAIL abort cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
    c = 0;
    build(1'b1, 24, -1, 0, -1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(M16, o, e);
      n_total++;
      if (o !== e) $display("FAIL abort_restart cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  task automatic test_reset_mid;
    out_t o, e;
    int c = 0;
    build(1'b0, 24, -1, 0, 13, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      step(U16, o, e);
      n_total++;
      if (o !== e) $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  task automatic test_start_busy;
    out_t o, e, z;
    stim_t s;
    int c = 0;
    z = '0;
    build(1'b0, 24, -1, 0, -1, 1'b0, 1'b1);
    s = stim_q[5];  s.start = 1'b1; stim_q[5] = s;
    s = stim_q[25]; s.start = 1'b1; stim_q[25] = s;
    build(1'b0, 24, -1, 0, -1, 1'b0, 1'b0);
    exp_q.push_back(z); stim_q.push_back(4'b1110);
    exp_q.push_back(z); stim_q.push_back(S_RV);
    exp_q.push_back(z); stim_q.push_back(S_RV);
    while (exp_q.size() > 0) begin
      step(U16, o, e);
      n_total++;
      if (o !== e) $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  task automatic test_width25;
    out_t o, e;
    int c = 0;
    build(1'b1, 12, -1, 0, -1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(M25, o, e);
      n_total++;
      if (o !== e) $display("FAIL w25_masked cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
    settle();
    c = 0;
    build(1'b0, 12, -1, 0, -1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      step(U25, o, e);
      n_total++;
      if (o !== e) $display("FAIL w25_unmasked cyc=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_unmasked();
    settle();
    test_masked_ideal();
    settle();
    test_masked_stall();
    settle();
    test_abort();
    settle();
    test_reset_mid();
    settle();
    test_start_busy();
    settle();
    test_width25();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
